// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: CP0 access, exception/ERET and redirect signals between the pipeline and CP0
interface cp0_regfile_if;
    logic        cp_read_en;
    logic [4:0]  cp_read_addr;
    logic [31:0] cp_read_data;
    logic        cp_write_en;
    logic [4:0]  cp_write_addr;
    logic [31:0] cp_write_data;
    logic [5:0]  hw_int;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delayslot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        int_pending;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] status_out;
    logic [31:0] cause_out;
    logic [31:0] epc_out;

    modport master (
        output cp_read_en, cp_read_addr, cp_write_en, cp_write_addr, cp_write_data, hw_int,
               exc_valid, exc_code, exc_pc, exc_delayslot, exc_badvaddr, eret,
        input  cp_read_data, int_pending, redirect_en, redirect_pc, status_out, cause_out, epc_out
    );

    modport slave (
        input  cp_read_en, cp_read_addr, cp_write_en, cp_write_addr, cp_write_data, hw_int,
               exc_valid, exc_code, exc_pc, exc_delayslot, exc_badvaddr, eret,
        output cp_read_data, int_pending, redirect_en, redirect_pc, status_out, cause_out, epc_out
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 registers, exception/ERET recording, interrupt detect and PC redirect.
// Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_regfile #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input logic           clk,
    input logic           rst,
    cp0_regfile_if.slave  bus
);
    logic [31:0] badvaddr, epc, status, cause, status_w, cause_w, wd, rd;
    logic [7:0]  im;
    logic [5:0]  hw_ip;
    logic [4:0]  exc_code_r, wa, ra;
    logic [1:0]  sw_ip;
    logic        exl, ie, bd, fwd, wr, timer_hw;

    assign wd = bus.cp_write_data;
    assign wa = bus.cp_write_addr;
    assign ra = bus.cp_read_addr;
    assign wr = bus.cp_write_en & ~bus.exc_valid;
    assign fwd = bus.cp_write_en && wa == ra;

    assign status   = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    assign cause    = {bd, 15'd0, hw_ip, sw_ip, 1'b0, exc_code_r, 2'b00};
    assign status_w = {9'd0, 1'b1, 6'd0, wd[15:8], 6'd0, wd[1:0]};
    assign cause_w  = {bd, 15'd0, hw_ip, wd[9:8], 1'b0, exc_code_r, 2'b00};

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare, count_inc;
    logic        tick, timer_int, wr_count, wr_compare;

    assign count_inc  = count + 32'd1;
    assign wr_count   = wr && wa == 5'd9;
    assign wr_compare = wr && wa == 5'd11;
    assign timer_hw   = timer_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            compare   <= '0;
            tick      <= 1'b0;
            timer_int <= 1'b0;
        end else begin
            tick      <= wr_count ? 1'b0 : ~tick;
            count     <= wr_count ? wd : tick ? count_inc : count;
            compare   <= wr_compare ? wd : compare;
            timer_int <= wr_compare ? 1'b0 : (tick && !wr_count && count_inc == compare) ? 1'b1 : timer_int;
        end
    end
`else
    assign timer_hw = 1'b0;
`endif

    always_comb begin
        rd = '0;
        case (ra)
            5'd8:    rd = badvaddr;
`ifdef CP0_TIMER_EN
            5'd9:    rd = fwd ? wd : count;
            5'd11:   rd = fwd ? wd : compare;
`endif
            5'd12:   rd = fwd ? status_w : status;
            5'd13:   rd = fwd ? cause_w : cause;
            5'd14:   rd = fwd ? wd : epc;
            5'd15:   rd = PRID_VALUE;
            default: rd = '0;
        endcase
    end

    assign bus.cp_read_data = bus.cp_read_en ? rd : '0;

    // ERET target forwards a same-cycle MTC0 to EPC
    assign bus.redirect_en = bus.exc_valid | bus.eret;
    assign bus.redirect_pc = bus.exc_valid ? EXC_VECTOR :
                             bus.eret ? ((bus.cp_write_en && wa == 5'd14) ? wd : epc) : '0;
    assign bus.int_pending = ie & ~exl & |({hw_ip, sw_ip} & im);
    assign bus.status_out  = status;
    assign bus.cause_out   = cause;
    assign bus.epc_out     = epc;

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr   <= '0;
            epc        <= '0;
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            exc_code_r <= '0;
            hw_ip      <= '0;
            sw_ip      <= '0;
        end else begin
            hw_ip <= {bus.hw_int[5] | timer_hw, bus.hw_int[4:0]};
            if (bus.exc_valid) begin
                if (!exl) begin
                    epc <= bus.exc_delayslot ? bus.exc_pc - 32'd4 : bus.exc_pc;
                    bd  <= bus.exc_delayslot;
                end
                exl        <= 1'b1;
                exc_code_r <= bus.exc_code;
                if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5)
                    badvaddr <= bus.exc_badvaddr;
            end else begin
                if (wr && wa == 5'd12) begin
                    im <= wd[15:8];
                    ie <= wd[0];
                end
                exl <= bus.eret ? 1'b0 : (wr && wa == 5'd12) ? wd[1] : exl;
                if (wr && wa == 5'd13)
                    sw_ip <= wd[9:8];
                if (wr && wa == 5'd14)
                    epc <= wd;
            end
        end
    end
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: scoreboard bench for cp0_regfile; inputs driven on negedge, outputs sampled before posedge
module tb_cp0_regfile;
    logic clk = 1'b0;
    logic rst;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    cp0_regfile_if bus();
    cp0_regfile dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.cp_read_en = 0; bus.cp_read_addr = 0; bus.cp_write_en = 0; bus.cp_write_addr = 0;
        bus.cp_write_data = 0; bus.hw_int = 0; bus.exc_valid = 0; bus.exc_code = 0; bus.exc_pc = 0;
        bus.exc_delayslot = 0; bus.exc_badvaddr = 0; bus.eret = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp_write_en = 1; bus.cp_write_addr = a; bus.cp_write_data = d;
        cyc();
        bus.cp_write_en = 0;
    endtask

    task automatic test_reset();
        logic [4:0]  addrs[9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd31};
        logic [31:0] exps[9]  = '{0, 0, 0, 32'h0040_0000, 0, 0, 32'h0000_4220, 0, 0};
        rst = 1;
        repeat (2) cyc();
        rst = 0;
        exp_q.push_back(32'h0040_0000); #1; e = exp_q.pop_front(); vectors++;
        if (bus.status_out !== e) begin miscompares++; $display("FAIL reset_status got %h exp %h", bus.status_out, e); end
        exp_q.push_back(32'h0); e = exp_q.pop_front(); vectors++;
        if (bus.cause_out !== e) begin miscompares++; $display("FAIL reset_cause got %h exp %h", bus.cause_out, e); end
        exp_q.push_back(32'h0); e = exp_q.pop_front(); vectors++;
        if (bus.epc_out !== e) begin miscompares++; $display("FAIL reset_epc got %h exp %h", bus.epc_out, e); end
        exp_q.push_back(32'h0); e = exp_q.pop_front(); vectors++;
        if ({bus.redirect_en, bus.int_pending, bus.redirect_pc} !== {2'b00, e}) begin
            miscompares++; $display("FAIL reset_redirect got %b/%b/%h exp 0/0/%h", bus.redirect_en, bus.int_pending, bus.redirect_pc, e);
        end
        bus.cp_read_en = 1;
        for (int i = 0; i < 9; i++) begin
            bus.cp_read_addr = addrs[i];
            exp_q.push_back(exps[i]); #1; e = exp_q.pop_front(); vectors++;
            if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL reset_read%0d got %h exp %h", addrs[i], bus.cp_read_data, e); end
        end
        bus.cp_read_en = 0; bus.cp_read_addr = 15;
        exp_q.push_back(32'h0); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL read_disabled got %h exp %h", bus.cp_read_data, e); end
    endtask

    task automatic test_status_write();
        bus.cp_write_en = 1; bus.cp_write_addr = 12; bus.cp_write_data = 32'hFFFF_FFFF;
        bus.cp_read_en = 1; bus.cp_read_addr = 12;
        exp_q.push_back(32'h0040_FF03); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL status_fwd got %h exp %h", bus.cp_read_data, e); end
        cyc(); bus.cp_write_en = 0;
        exp_q.push_back(32'h0040_FF03); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL status_mfc0 got %h exp %h", bus.cp_read_data, e); end
        mtc0(13, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0300); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cause_out !== e) begin miscompares++; $display("FAIL cause_mask got %h exp %h", bus.cause_out, e); end
        mtc0(13, 0);
        mtc0(8, 32'hFFFF_FFFF); mtc0(15, 32'hFFFF_FFFF); mtc0(14, 32'h1234_5678);
        bus.cp_read_addr = 8;
        exp_q.push_back(32'h0); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL badvaddr_ro got %h exp %h", bus.cp_read_data, e); end
        bus.cp_read_addr = 15;
        exp_q.push_back(32'h0000_4220); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL prid_ro got %h exp %h", bus.cp_read_data, e); end
        bus.cp_read_addr = 14;
        exp_q.push_back(32'h1234_5678); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL epc_rw got %h exp %h", bus.cp_read_data, e); end
        mtc0(12, 0);
    endtask

    task automatic test_exception();
        bus.exc_valid = 1; bus.exc_code = 4; bus.exc_pc = 32'h8000_0104; bus.exc_delayslot = 1; bus.exc_badvaddr = 32'h1233;
        exp_q.push_back(32'hBFC0_0380); #1; e = exp_q.pop_front(); vectors++;
        if (bus.redirect_en !== 1'b1 || bus.redirect_pc !== e) begin
            miscompares++; $display("FAIL exc_redirect got %b/%h exp 1/%h", bus.redirect_en, bus.redirect_pc, e);
        end
        cyc(); bus.exc_valid = 0;
        exp_q.push_back(32'h8000_0100); #1; e = exp_q.pop_front(); vectors++;
        if (bus.epc_out !== e) begin miscompares++; $display("FAIL exc_epc got %h exp %h", bus.epc_out, e); end
        exp_q.push_back(32'h8000_0010); e = exp_q.pop_front(); vectors++;
        if (bus.cause_out !== e) begin miscompares++; $display("FAIL exc_cause got %h exp %h", bus.cause_out, e); end
        exp_q.push_back(32'h0040_0002); e = exp_q.pop_front(); vectors++;
        if (bus.status_out !== e) begin miscompares++; $display("FAIL exc_status got %h exp %h", bus.status_out, e); end
        bus.cp_read_en = 1; bus.cp_read_addr = 8;
        exp_q.push_back(32'h0000_1233); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL exc_badvaddr got %h exp %h", bus.cp_read_data, e); end
        bus.exc_valid = 1; bus.exc_code = 0; bus.exc_pc = 32'h8000_0300; bus.exc_delayslot = 0; bus.exc_badvaddr = 32'h5555;
        cyc(); bus.exc_valid = 0;
        exp_q.push_back(32'h8000_0100); #1; e = exp_q.pop_front(); vectors++;
        if (bus.epc_out !== e) begin miscompares++; $display("FAIL nested_epc got %h exp %h", bus.epc_out, e); end
        exp_q.push_back(32'h8000_0000); e = exp_q.pop_front(); vectors++;
        if (bus.cause_out !== e) begin miscompares++; $display("FAIL nested_cause got %h exp %h", bus.cause_out, e); end
        exp_q.push_back(32'h0000_1233); e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL nested_badvaddr got %h exp %h", bus.cp_read_data, e); end
    endtask

    task automatic test_eret();
        mtc0(14, 32'h8000_0200);
        bus.eret = 1;
        exp_q.push_back(32'h8000_0200); #1; e = exp_q.pop_front(); vectors++;
        if (bus.redirect_en !== 1'b1 || bus.redirect_pc !== e) begin
            miscompares++; $display("FAIL eret_redirect got %b/%h exp 1/%h", bus.redirect_en, bus.redirect_pc, e);
        end
        cyc(); bus.eret = 0;
        exp_q.push_back(32'h0040_0000); #1; e = exp_q.pop_front(); vectors++;
        if (bus.status_out !== e) begin miscompares++; $display("FAIL eret_exl got %h exp %h", bus.status_out, e); end
        bus.eret = 1; bus.cp_write_en = 1; bus.cp_write_addr = 14; bus.cp_write_data = 32'h8000_0400;
        exp_q.push_back(32'h8000_0400); #1; e = exp_q.pop_front(); vectors++;
        if (bus.redirect_pc !== e) begin miscompares++; $display("FAIL eret_fwd got %h exp %h", bus.redirect_pc, e); end
        cyc(); bus.eret = 0; bus.cp_write_en = 0;
        exp_q.push_back(32'h8000_0400); #1; e = exp_q.pop_front(); vectors++;
        if (bus.epc_out !== e) begin miscompares++; $display("FAIL eret_mtc0 got %h exp %h", bus.epc_out, e); end
        bus.exc_valid = 1; bus.exc_code = 8; bus.exc_pc = 32'h8000_0500; bus.exc_delayslot = 0; bus.eret = 1;
        bus.cp_write_en = 1; bus.cp_write_addr = 14; bus.cp_write_data = 32'h1111_1111;
        exp_q.push_back(32'hBFC0_0380); #1; e = exp_q.pop_front(); vectors++;
        if (bus.redirect_pc !== e) begin miscompares++; $display("FAIL exc_eret_pc got %h exp %h", bus.redirect_pc, e); end
        cyc(); bus.exc_valid = 0; bus.eret = 0; bus.cp_write_en = 0;
        exp_q.push_back(32'h8000_0500); #1; e = exp_q.pop_front(); vectors++;
        if (bus.epc_out !== e) begin miscompares++; $display("FAIL exc_eret_epc got %h exp %h", bus.epc_out, e); end
        exp_q.push_back(32'h0040_0002); e = exp_q.pop_front(); vectors++;
        if (bus.status_out !== e) begin miscompares++; $display("FAIL exc_eret_status got %h exp %h", bus.status_out, e); end
        exp_q.push_back(32'h0000_0020); e = exp_q.pop_front(); vectors++;
        if (bus.cause_out !== e) begin miscompares++; $display("FAIL exc_eret_cause got %h exp %h", bus.cause_out, e); end
        exp_q.push_back(32'h0); e = exp_q.pop_front(); vectors++;
        if (bus.redirect_en !== 1'b0 || bus.redirect_pc !== e) begin
            miscompares++; $display("FAIL idle_redirect got %b/%h exp 0/%h", bus.redirect_en, bus.redirect_pc, e);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] sts[4] = '{32'h0040_0401, 32'h0040_0403, 32'h0040_0801, 32'h0040_0101};
        logic [5:0]  hws[4] = '{6'd1, 6'd1, 6'd1, 6'd0};
        logic [31:0] sws[4] = '{0, 0, 0, 32'h100};
        logic        pend[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.hw_int = hws[i];
            mtc0(13, sws[i]);
            mtc0(12, sts[i]);
            exp_q.push_back({31'd0, pend[i]}); #1; e = exp_q.pop_front(); vectors++;
            if (bus.int_pending !== e[0]) begin miscompares++; $display("FAIL int_pending%0d got %b exp %b", i, bus.int_pending, e[0]); end
        end
        bus.hw_int = 0;
        mtc0(13, 0); mtc0(12, 0);
    endtask

    task automatic test_back_to_back();
        bus.cp_write_en = 1; bus.cp_write_addr = 14; bus.cp_read_en = 1; bus.cp_read_addr = 14;
        for (int i = 0; i < 5; i++) begin
            bus.cp_write_data = 32'h8000_1000 + 32'(i) * 8;
            exp_q.push_back(32'h8000_1000 + 32'(i) * 8); #1; e = exp_q.pop_front(); vectors++;
            if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL b2b_fwd%0d got %h exp %h", i, bus.cp_read_data, e); end
            exp_q.push_back(32'h8000_1000 + 32'(i) * 8);
            cyc();
            e = exp_q.pop_front(); vectors++;
            if (bus.epc_out !== e) begin miscompares++; $display("FAIL b2b_epc%0d got %h exp %h", i, bus.epc_out, e); end
        end
        bus.cp_write_en = 0;
    endtask

    task automatic test_reset_priority();
        bus.exc_valid = 1; bus.exc_code = 4; bus.exc_pc = 32'h8000_0700; bus.exc_badvaddr = 32'hABCD;
        bus.cp_write_en = 1; bus.cp_write_addr = 12; bus.cp_write_data = 32'hFFFF_FFFF; bus.hw_int = 6'h3F;
        rst = 1;
        cyc();
        rst = 0; idle();
        exp_q.push_back(32'h0040_0000); #1; e = exp_q.pop_front(); vectors++;
        if (bus.status_out !== e) begin miscompares++; $display("FAIL rstmid_status got %h exp %h", bus.status_out, e); end
        exp_q.push_back(32'h0); e = exp_q.pop_front(); vectors++;
        if (bus.epc_out !== e || bus.cause_out !== e) begin
            miscompares++; $display("FAIL rstmid_epc_cause got %h/%h exp %h", bus.epc_out, bus.cause_out, e);
        end
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        mtc0(11, 3);
        repeat (5) cyc();
        exp_q.push_back(32'h0); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cause_out[15] !== e[0]) begin miscompares++; $display("FAIL timer_early got %b exp %b", bus.cause_out[15], e[0]); end
        cyc();
        exp_q.push_back(32'h1); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cause_out[15] !== e[0]) begin miscompares++; $display("FAIL timer_fire got %b exp %b", bus.cause_out[15], e[0]); end
        mtc0(11, 100);
        cyc();
        exp_q.push_back(32'h0); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cause_out[15] !== e[0]) begin miscompares++; $display("FAIL timer_clear got %b exp %b", bus.cause_out[15], e[0]); end
        mtc0(9, 32'hFFFF_FFFF);
        bus.cp_read_en = 1; bus.cp_read_addr = 9;
        cyc();
        exp_q.push_back(32'hFFFF_FFFF); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL count_hold got %h exp %h", bus.cp_read_data, e); end
        cyc();
        exp_q.push_back(32'h0); #1; e = exp_q.pop_front(); vectors++;
        if (bus.cp_read_data !== e) begin miscompares++; $display("FAIL count_wrap got %h exp %h", bus.cp_read_data, e); end
    endtask
`endif

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_status_write();
        test_exception();
        test_eret();
        test_interrupt();
        test_back_to_back();
        test_reset_priority();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- CP0 register file: the responder for the CP0 read/write address and enable signals that the ID stage generates for MFC0/MTC0.
- Holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId.
- Records exceptions and ERET arriving from the MEM/commit stage, computes the pending interrupt, and drives the PC redirect.
- Sits beside the GPR file. Reads feed the ID stage; writes and exceptions come from commit.

Parameters:
- PRID_VALUE, 32'h0000_4220, read-only value of PRId (reg 15).
- EXC_VECTOR, 32'hBFC0_0380, target PC for every exception.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cp_read_en  in  1  MFC0 read enable
- cp_read_addr  in  5  CP0 register number to read
- cp_read_data  out  32  read data (combinational)
- cp_write_en  in  1  MTC0 write enable (commit stage)
- cp_write_addr  in  5  CP0 register number to write
- cp_write_data  in  32  write data
- hw_int  in  6  external hardware interrupt lines
- exc_valid  in  1  exception committed this cycle
- exc_code  in  5  ExcCode of the committed exception
- exc_pc  in  32  PC of the faulting instruction
- exc_delayslot  in  1  faulting instruction is in a delay slot
- exc_badvaddr  in  32  faulting address (AdEL/AdES)
- eret  in  1  ERET committed this cycle
- int_pending  out  1  interrupt is to be taken
- redirect_en  out  1  flush and redirect the PC this cycle
- redirect_pc  out  32  target PC for the redirect
- status_out  out  32  current Status register
- cause_out  out  32  current Cause register
- epc_out  out  32  current EPC register

Behaviour:
- Reset (rst=1 at a clk edge):
  - BadVAddr=0, Count=0, Compare=0, EPC=0, Cause=0.
  - Status=32'h0040_0000 (BEV=1, all other bits 0).
  - Internal tick=0, timer_int=0.
  - Reset mid-operation wins over every other event in that cycle.
- Read path (combinational):
  - cp_read_en=0 gives cp_read_data=0.
  - Register numbers outside {8,9,11,12,13,14,15} read as 0.
  - Same-cycle write forwarding: if cp_write_en is high and cp_write_addr==cp_read_addr, cp_read_data returns the post-write masked value.
- Write masks (MTC0, applied at the clk edge):
  - Status: only IM[15:8], EXL[1] and IE[0] are writable. BEV[22] always reads 1. All other bits read 0.
  - Cause: only IP[9:8] (software interrupts) are writable.
  - EPC: all 32 bits writable.
  - Compare: all 32 bits writable; also clears timer_int.
  - Count: all 32 bits writable; also clears tick.
  - BadVAddr and PRId: writes are ignored.
- Cause hardware bits, sampled every cycle:
  - Cause[15:10] = {hw_int[5] | timer_int, hw_int[4:0]}.
  - Cause[31]=BD, Cause[6:2]=ExcCode. All other bits read 0.
- Exception (exc_valid=1). Highest priority of the non-reset events; same-cycle eret and cp_write_en are ignored.
  - If Status.EXL was 0:
    - EPC = exc_delayslot ? exc_pc-4 : exc_pc.
    - Cause.BD = exc_delayslot.
  - If Status.EXL was 1: EPC and BD are unchanged.
  - Status.EXL is set to 1.
  - Cause.ExcCode = exc_code.
  - BadVAddr = exc_badvaddr only when exc_code is 4 (AdEL) or 5 (AdES).
  - redirect_en=1 and redirect_pc=EXC_VECTOR, combinationally in the same cycle.
- ERET (eret=1, exc_valid=0). Ignored when exc_valid=1.
  - Status.EXL is cleared at the clk edge.
  - redirect_en=1 and redirect_pc = EPC, using the pre-edge value, or cp_write_data if an MTC0 to EPC is in the same cycle.
  - The MTC0 in that cycle still takes effect.
- Otherwise: redirect_en=0 and redirect_pc=0.
- int_pending = Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]).
  - Purely combinational from register state.
  - Feeding int_pending back as exc_valid with code 0 is the commit stage's job, not this block's.
- status_out, cause_out and epc_out are the register contents. They reset to the reset values listed above.

Optional Feature:
- CP0_TIMER_EN defined:
  - tick toggles every cycle; Count increments by 1 (wrapping 32'hFFFF_FFFF to 0) on the cycle where tick==1.
  - timer_int is set when the incremented Count equals Compare. It stays set until Compare is written.
  - An MTC0 to Count in the same cycle overrides the increment.
- CP0_TIMER_EN undefined:
  - Count, Compare, tick and timer_int are absent.
  - Reg 9 and reg 11 read 0 and writes to them are ignored.
  - Cause[15] = hw_int[5] only.

Test Plan:
- Reset, then read Status (reg 12) and PRId (reg 15) -> 32'h0040_0000 and 32'h0000_4220; all other readable registers return 0.
- MTC0 Status=32'hFFFF_FFFF, then MFC0 -> 32'h0040_FF03; in the same cycle, read reg 12 -> forwarded 32'h0040_FF03.
- exc_valid, code 4, exc_pc=32'h8000_0104, delayslot=1, badvaddr=32'h1233 -> redirect_pc=32'hBFC0_0380; next cycle EPC=32'h8000_0100, BD=1, EXL=1, BadVAddr=32'h1233. A second exception with EXL=1 leaves EPC unchanged.
- ERET with EPC=32'h8000_0200 -> redirect_en=1, redirect_pc=32'h8000_0200, EXL=0 next cycle. exc_valid and eret together -> exception only.
- Status=32'h0040_0401 and hw_int[0]=1 -> int_pending=1. Setting EXL drives it to 0.
- With CP0_TIMER_EN: Compare=3 -> timer_int and Cause[15] set 6 cycles after reset release; writing Compare clears them. Count=32'hFFFF_FFFF -> wraps to 0.
